rmii_frame_checker: RTL and testbench

Receive-side frame checker for the 50 MHz RMII link. It deserialises 2-bit RMII dibits (LSB first), locks on preamble/SFD, checks CRC-32, length and alignment, and captures the MAC header. It reports one status pulse per frame and keeps saturating good/bad counters. It sits on the `tx_en`/`txd` output of `packet_tx` for loopback and self-check, and can also tap any RMII receive pair.

---
 rtl/ethernet_header_pkg.sv | 24 ++
 rtl/crc32_dibit.sv | 24 ++
 rtl/rmii_frame_checker.sv | 176 +++++++++++++++++
 tb/tb_rmii_frame_checker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ethernet_header_pkg.sv
// Shared Ethernet constants and types for the RMII receive/transmit path.
package ethernet_header_pkg;

   localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
   localparam logic [1:0]  DIBIT_PRE     = 2'b01;
   localparam logic [1:0]  DIBIT_SFD     = 2'b11;
   localparam int          HDR_BYTES     = 14;

   typedef struct packed {
      logic        fcs_ok;
      logic        len_err;
      logic        align_err;
      logic [10:0] bytes;
   } frame_status_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2,
      DROP     = 2'd3
   } rx_state_t;

endpackage

// File: rtl/crc32_dibit.sv
// Combinational CRC-32 advance by one RMII dibit (reflected polynomial,
// bit [0] of the dibit enters first).
module crc32_dibit
   import ethernet_header_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [1:0]  dibit,
   output logic [31:0] crc_out
);

   logic [2:0][31:0] stage;

   assign stage[0] = crc_in;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bit
         assign stage[gi+1] = (stage[gi][0] ^ dibit[gi]) ? ((stage[gi] >> 1) ^ CRC32_POLY)
                                                          : (stage[gi] >> 1);
      end
   endgenerate

   assign crc_out = stage[2];

endmodule

// File: rtl/rmii_frame_checker.sv
// RMII receive frame checker: preamble/SFD lock, CRC-32, length and
// alignment checks, live MAC header capture, per-frame status pulse and
// saturating good/bad frame counters.
module rmii_frame_checker
   import ethernet_header_pkg::*;
#(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_dv,
   input  logic [1:0]       rxd,
   output logic             status_valid,
   output logic             status_fcs_ok,
   output logic             status_len_err,
   output logic             status_align_err,
   output logic [10:0]      status_bytes,
   output logic [47:0]      dest_mac,
   output logic [47:0]      src_mac,
   output logic [15:0]      ethertype,
   output logic [CNT_W-1:0] good_cnt,
   output logic [CNT_W-1:0] bad_cnt
);

   localparam logic [10:0] BYTES_SAT = 11'h7FF;

   rx_state_t         state_reg, state_next;
   logic [1:0]        run_reg;
   logic [1:0]        idx_reg;
   logic [5:0]        byte_sr_reg;
   logic [10:0]       byte_cnt_reg;
   logic [31:0]       crc_reg;
   logic [31:0]       crc_step;
   frame_status_t     status_reg;
   logic              status_valid_reg;
   logic [CNT_W-1:0]  good_reg, bad_reg;
   logic [HDR_BYTES-1:0][7:0] hdr_bus;

   logic              sfd_hit, frame_end, data_beat, byte_done;
   logic              align_err, fcs_ok, len_err;
   logic [7:0]        cur_byte;

   crc32_dibit u_crc (
      .crc_in  (crc_reg),
      .dibit   (rxd),
      .crc_out (crc_step)
   );

   assign data_beat = (state_reg == DATA) && rx_dv;
   assign byte_done = data_beat && (idx_reg == 2'd3);
   assign cur_byte  = {rxd, byte_sr_reg};
   assign align_err = (idx_reg != 2'd0);
   assign fcs_ok    = (crc_reg == CRC32_RESIDUE) && !align_err;
   assign len_err   = (int'(byte_cnt_reg) < MIN_FRAME) || (int'(byte_cnt_reg) > MAX_FRAME);

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   // Next-state logic plus the SFD-lock and end-of-frame strobes.
   always_comb begin
      state_next = state_reg;
      sfd_hit    = 1'b0;
      frame_end  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rx_dv) state_next = (rxd == DIBIT_PRE) ? PREAMBLE : DROP;
         end
         PREAMBLE: begin
            if (!rx_dv) begin
               state_next = IDLE;
            end else if (rxd == DIBIT_PRE) begin
               state_next = PREAMBLE;
            end else if ((rxd == DIBIT_SFD) && (run_reg == 2'd3)) begin
               state_next = DATA;
               sfd_hit    = 1'b1;
            end else begin
               state_next = DROP;
            end
         end
         DATA: begin
            if (!rx_dv) begin
               state_next = IDLE;
               frame_end  = 1'b1;
            end
         end
         DROP: begin
            if (!rx_dv) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Preamble run length (saturates at 3; the entering dibit counts as 1).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_reg <= 2'd0;
      end else if (state_reg == IDLE) begin
         run_reg <= 2'd1;
      end else if ((state_reg == PREAMBLE) && rx_dv && (rxd == DIBIT_PRE) && (run_reg != 2'd3)) begin
         run_reg <= run_reg + 2'd1;
      end
   end

   // Dibit index, byte assembly, byte count and running CRC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_reg      <= 2'd0;
         byte_sr_reg  <= 6'd0;
         byte_cnt_reg <= 11'd0;
         crc_reg      <= 32'hFFFF_FFFF;
      end else if (sfd_hit) begin
         idx_reg      <= 2'd0;
         byte_cnt_reg <= 11'd0;
         crc_reg      <= 32'hFFFF_FFFF;
      end else if (data_beat) begin
         crc_reg     <= crc_step;
         idx_reg     <= idx_reg + 2'd1;
         byte_sr_reg <= {rxd, byte_sr_reg[5:2]};
         if (byte_done && (byte_cnt_reg != BYTES_SAT)) byte_cnt_reg <= byte_cnt_reg + 11'd1;
      end
   end

   // One capture register per header byte; each loads when its byte position completes.
   generate
      for (genvar gi = 0; gi < HDR_BYTES; gi++) begin : g_hdr
         logic [7:0] hdr_byte_reg;
         // Clear at SFD so short frames leave unreceived header bytes at zero.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)                                           hdr_byte_reg <= 8'd0;
            else if (sfd_hit)                                   hdr_byte_reg <= 8'd0;
            else if (byte_done && (byte_cnt_reg == 11'(gi)))    hdr_byte_reg <= cur_byte;
         end
         assign hdr_bus[gi] = hdr_byte_reg;
      end
   endgenerate

   // Status register and saturating frame counters, updated at end of frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_valid_reg <= 1'b0;
         status_reg       <= '0;
         good_reg         <= '0;
         bad_reg          <= '0;
      end else begin
         status_valid_reg <= frame_end;
         if (frame_end) begin
            status_reg.fcs_ok    <= fcs_ok;
            status_reg.len_err   <= len_err;
            status_reg.align_err <= align_err;
            status_reg.bytes     <= byte_cnt_reg;
            if (fcs_ok && !len_err) begin
               if (good_reg != '1) good_reg <= good_reg + CNT_W'(1);
            end else begin
               if (bad_reg != '1) bad_reg <= bad_reg + CNT_W'(1);
            end
         end
      end
   end

   assign status_valid     = status_valid_reg;
   assign status_fcs_ok    = status_reg.fcs_ok;
   assign status_len_err   = status_reg.len_err;
   assign status_align_err = status_reg.align_err;
   assign status_bytes     = status_reg.bytes;
   assign dest_mac         = {hdr_bus[0], hdr_bus[1], hdr_bus[2], hdr_bus[3], hdr_bus[4], hdr_bus[5]};
   assign src_mac          = {hdr_bus[6], hdr_bus[7], hdr_bus[8], hdr_bus[9], hdr_bus[10], hdr_bus[11]};
   assign ethertype        = {hdr_bus[12], hdr_bus[13]};
   assign good_cnt         = good_reg;
   assign bad_cnt          = bad_reg;

endmodule

// File: tb/tb_rmii_frame_checker.sv
// Scoreboard bench for rmii_frame_checker: frames are built with a byte-level
// CRC-32 model, expectations are queued at issue time and a monitor checks
// every status pulse.
module tb_rmii_frame_checker;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             rx_dv = 1'b0;
   logic [1:0]       rxd = 2'b00;
   logic             status_valid, status_fcs_ok, status_len_err, status_align_err;
   logic [10:0]      status_bytes;
   logic [47:0]      dest_mac, src_mac;
   logic [15:0]      ethertype;
   logic [CNT_W-1:0] good_cnt, bad_cnt;

   rmii_frame_checker #(.MIN_FRAME(64), .MAX_FRAME(1518), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .rx_dv            (rx_dv),
      .rxd              (rxd),
      .status_valid     (status_valid),
      .status_fcs_ok    (status_fcs_ok),
      .status_len_err   (status_len_err),
      .status_align_err (status_align_err),
      .status_bytes     (status_bytes),
      .dest_mac         (dest_mac),
      .src_mac          (src_mac),
      .ethertype        (ethertype),
      .good_cnt         (good_cnt),
      .bad_cnt          (bad_cnt)
   );

   always #10 clk = ~clk;

   typedef logic [7:0] byte_q_t[$];

   typedef struct packed {
      logic        fcs_ok;
      logic        len_err;
      logic        align_err;
      logic [10:0] bytes;
      logic [47:0] dest;
      logic [47:0] src;
      logic [15:0] etype;
      logic [15:0] good;
      logic [15:0] bad;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          frames_seen = 0;
   logic [15:0] good_m = 16'd0;
   logic [15:0] bad_m = 16'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Standard Ethernet CRC-32 over the first n bytes, final value inverted.
   function automatic logic [31:0] crc32(input byte_q_t d, input int n);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'h0, d[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic build(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                        input byte_q_t pl, output byte_q_t fr);
      logic [31:0] c;
      fr = {};
      for (int k = 5; k >= 0; k--) fr.push_back(d[8*k +: 8]);
      for (int k = 5; k >= 0; k--) fr.push_back(s[8*k +: 8]);
      fr.push_back(et[15:8]);
      fr.push_back(et[7:0]);
      foreach (pl[i]) fr.push_back(pl[i]);
      c = crc32(fr, fr.size());
      for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
   endtask

   task automatic send_dibit(input logic dv, input logic [1:0] d);
      @(posedge clk);
      #1;
      rx_dv = dv;
      rxd   = d;
   endtask

   // Preamble + SFD, frame bytes LSB dibit first, optional trailing dibits, optional rx_dv drop.
   task automatic send_frame(input byte_q_t fr, input int extra, input bit finish);
      for (int i = 0; i < 31; i++) send_dibit(1'b1, 2'b01);
      send_dibit(1'b1, 2'b11);
      foreach (fr[i]) for (int k = 0; k < 4; k++) send_dibit(1'b1, fr[i][2*k +: 2]);
      for (int i = 0; i < extra; i++) send_dibit(1'b1, 2'($urandom));
      if (finish) send_dibit(1'b0, 2'b00);
   endtask

   // Reference model: derive expected status from the frame contents, queue it, then send.
   task automatic issue(input byte_q_t fr, input int extra);
      exp_t       e;
      int         n;
      logic [7:0] h[14];
      logic [31:0] fcs_rx;
      n = fr.size();
      e.bytes     = (n > 2047) ? 11'd2047 : 11'(n);
      e.align_err = (extra % 4) != 0;
      e.len_err   = (n < 64) || (n > 1518);
      fcs_rx      = {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
      e.fcs_ok    = !e.align_err && (crc32(fr, n - 4) == fcs_rx);
      for (int k = 0; k < 14; k++) h[k] = (k < n) ? fr[k] : 8'h00;
      e.dest  = {h[0], h[1], h[2], h[3], h[4], h[5]};
      e.src   = {h[6], h[7], h[8], h[9], h[10], h[11]};
      e.etype = {h[12], h[13]};
      if (e.fcs_ok && !e.len_err && !e.align_err) begin
         if (good_m != 16'hFFFF) good_m = good_m + 16'd1;
      end else begin
         if (bad_m != 16'hFFFF) bad_m = bad_m + 16'd1;
      end
      e.good = good_m;
      e.bad  = bad_m;
      exp_q.push_back(e);
      send_frame(fr, extra, 1'b1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 64'(status_valid), 64'd0);
      check({tag, "_fcs_ok"}, 64'(status_fcs_ok), 64'd0);
      check({tag, "_bytes"}, 64'(status_bytes), 64'd0);
      check({tag, "_dest"}, 64'(dest_mac), 64'd0);
      check({tag, "_src"}, 64'(src_mac), 64'd0);
      check({tag, "_etype"}, 64'(ethertype), 64'd0);
      check({tag, "_good"}, 64'(good_cnt), 64'd0);
      check({tag, "_bad"}, 64'(bad_cnt), 64'd0);
   endtask

   // Monitor: every status pulse must match the oldest queued expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst && status_valid) begin
         frames_seen++;
         $display("frame %0d: bytes=%0d fcs_ok=%0d len_err=%0d align_err=%0d good=%0d bad=%0d",
                  frames_seen, status_bytes, status_fcs_ok, status_len_err, status_align_err,
                  good_cnt, bad_cnt);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_status actual=status_valid required=none_pending");
         end else begin
            e = exp_q.pop_front();
            check("fcs_ok", 64'(status_fcs_ok), 64'(e.fcs_ok));
            check("len_err", 64'(status_len_err), 64'(e.len_err));
            check("align_err", 64'(status_align_err), 64'(e.align_err));
            check("bytes", 64'(status_bytes), 64'(e.bytes));
            check("dest_mac", 64'(dest_mac), 64'(e.dest));
            check("src_mac", 64'(src_mac), 64'(e.src));
            check("ethertype", 64'(ethertype), 64'(e.etype));
            check("good_cnt", 64'(good_cnt), 64'(e.good));
            check("bad_cnt", 64'(bad_cnt), 64'(e.bad));
         end
      end
   end

   initial begin
      byte_q_t     pl, fr, base, part;
      logic [31:0] c;
      int          idx, len, mode;

      // Reset state.
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);

      // Good frame from the test plan.
      pl = {};
      repeat (63) pl.push_back(8'hAA);
      pl.push_back(8'hFF);
      build(48'h54e1ad330d32, 48'h00183e04b3f2, 16'h0040, pl, base);
      issue(base, 0);

      // Same frame with one payload bit flipped.
      fr  = base;
      idx = 14 + $urandom_range(0, 63);
      fr[idx] = fr[idx] ^ 8'(1 << $urandom_range(0, 7));
      issue(fr, 0);

      // Runt: 20-byte payload, valid FCS.
      pl = {};
      repeat (20) pl.push_back(8'($urandom));
      build(48'h54e1ad330d32, 48'h00183e04b3f2, 16'h0800, pl, fr);
      issue(fr, 0);

      // Good frame followed by 2 dibits of a partial byte.
      issue(base, 2);

      // Preamble corrupted by a 10 dibit, then a long rx_dv-high stretch.
      drain();
      for (int i = 0; i < 10; i++) send_dibit(1'b1, 2'b01);
      send_dibit(1'b1, 2'b10);
      repeat (100) send_dibit(1'b1, 2'($urandom));
      send_dibit(1'b0, 2'b00);
      repeat (4) @(negedge clk);
      check("drop_good_cnt", 64'(good_cnt), 64'(good_m));
      check("drop_bad_cnt", 64'(bad_cnt), 64'(bad_m));
      issue(base, 0);

      // Header-only short frame: 6 bytes + FCS.
      fr = {};
      repeat (6) fr.push_back(8'($urandom));
      c = crc32(fr, 6);
      for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
      issue(fr, 0);

      // Randomized frames: good, bit-flipped, or misaligned.
      for (int i = 0; i < 12; i++) begin
         len = $urandom_range(0, 90);
         pl  = {};
         for (int k = 0; k < len; k++) pl.push_back(8'($urandom));
         build({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), pl, fr);
         mode = $urandom_range(0, 2);
         if (mode == 1) begin
            idx = $urandom_range(0, fr.size() - 1);
            fr[idx] = fr[idx] ^ 8'(1 << $urandom_range(0, 7));
         end
         issue(fr, (mode == 2) ? $urandom_range(1, 3) : 0);
      end

      // Oversize frame and a frame long enough to saturate the byte count.
      pl = {};
      repeat (1520) pl.push_back(8'($urandom));
      build(48'h020000000001, 48'h020000000002, 16'h88b5, pl, fr);
      issue(fr, 0);
      repeat (580) pl.push_back(8'($urandom));
      build(48'h020000000003, 48'h020000000004, 16'h88b6, pl, fr);
      issue(fr, 0);

      // Reset in the middle of DATA, then a good frame.
      drain();
      part = {};
      for (int k = 0; k < 20; k++) part.push_back(base[k]);
      send_frame(part, 0, 1'b0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      rx_dv = 1'b0;
      good_m = 16'd0;
      bad_m  = 16'd0;
      repeat (2) @(negedge clk);
      check_all_zero("midreset");
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      issue(base, 0);

      drain();
      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
